// File: rtl/seq_mult_wide.sv
// Sequential signed/unsigned WIDTH x WIDTH multiplier built from one LIMB x LIMB
// unsigned multiplier, iterating over limb pairs with a valid/ready handshake.
module seq_mult_wide #(
  parameter int WIDTH = 72,
  parameter int LIMB  = 36
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 asign,
  input  logic                 bsign,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   dout,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int N  = (WIDTH + LIMB - 1) / LIMB;
  localparam int PW = N * LIMB;
  localparam int AW = 2 * PW;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, MUL, SIGN, DONE} state_t;

  state_t state, state_next;

  logic [PW-1:0]     a_mag, b_mag;
  logic [AW-1:0]     acc;
  logic [IW-1:0]     i, j;
  logic              neg;

  logic [WIDTH-1:0]  a_abs, b_abs;
  logic [LIMB-1:0]   a_limb, b_limb;
  logic [2*LIMB-1:0] limb_prod;
  logic [AW-1:0]     term;
  logic              accept, last_pair;

  // Negating in WIDTH bits maps the most negative value onto 2^(WIDTH-1),
  // which is exactly its magnitude once read as unsigned.
  assign a_abs = (asign && a[WIDTH-1]) ? -a : a;
  assign b_abs = (bsign && b[WIDTH-1]) ? -b : b;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = ce && in_valid && in_ready;
  assign last_pair = (i == LAST) && (j == LAST);

  assign a_limb    = a_mag[i*LIMB +: LIMB];
  assign b_limb    = b_mag[j*LIMB +: LIMB];
  assign limb_prod = {{LIMB{1'b0}}, a_limb} * {{LIMB{1'b0}}, b_limb};
  assign term      = AW'(limb_prod) << (LIMB * (int'(i) + int'(j)));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept)                state_next = MUL;
      MUL:  if (ce && last_pair)       state_next = SIGN;
      SIGN: if (ce)                    state_next = DONE;
      DONE: if (ce && out_ready)       state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_mag <= '0;
      b_mag <= '0;
      acc   <= '0;
      i     <= '0;
      j     <= '0;
      neg   <= 1'b0;
      dout  <= '0;
    end else if (ce) begin
      case (state)
        IDLE: if (in_valid) begin
          a_mag <= PW'(a_abs);
          b_mag <= PW'(b_abs);
          neg   <= (asign & a[WIDTH-1]) ^ (bsign & b[WIDTH-1]);
          acc   <= '0;
          i     <= '0;
          j     <= '0;
        end
        MUL: begin
          acc <= acc + term;
          if (j == LAST) begin
            j <= '0;
            i <= last_pair ? '0 : i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        // Magnitude product fits in 2*WIDTH bits, so the truncated negation
        // is the exact two's-complement result.
        SIGN: dout <= (2*WIDTH)'(neg ? -acc : acc);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_wide.sv
// Scoreboard bench for seq_mult_wide (WIDTH=36, LIMB=18): directed vectors,
// ce stalls, output backpressure and asynchronous reset during a multiply.
module tb_seq_mult_wide;

  localparam int WIDTH = 36;
  localparam int LIMB  = 18;
  localparam int N     = 2;
  localparam int LAT   = N * N + 1;

  logic              clk = 1'b0;
  logic              reset, ce;
  logic [WIDTH-1:0]  a, b;
  logic              asign, bsign, in_valid, in_ready;
  logic [2*WIDTH-1:0] dout;
  logic              out_valid, out_ready;

  typedef struct {
    logic [71:0] want;
    int          rise;
  } exp_t;

  typedef struct {
    logic [35:0] va, vb;
    logic        sa, sb;
    logic [71:0] p;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  logic ov_prev  = 1'b0;

  seq_mult_wide #(.WIDTH(WIDTH), .LIMB(LIMB)) dut (
    .clk(clk), .reset(reset), .ce(ce), .a(a), .b(b),
    .asign(asign), .bsign(bsign), .in_valid(in_valid), .in_ready(in_ready),
    .dout(dout), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input logic [71:0] act, input logic [71:0] want, input string name);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: samples mid-cycle, so the values seen are those the next edge uses.
  always @(negedge clk) begin
    if (out_valid && !ov_prev) begin
      if (sbq.size() == 0) check(72'(out_valid), 72'd0, "spurious_out_valid");
      else                 check(72'(edge_cnt), 72'(sbq[0].rise), "latency");
    end
    if (out_valid && sbq.size() != 0) begin
      check(dout, sbq[0].want, "dout");
      check(72'(in_ready), 72'd0, "in_ready_busy");
      if (ce && out_ready) void'(sbq.pop_front());
    end
    ov_prev <= out_valid;
  end

  task automatic wait_idle();
    int k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check(72'(in_ready), 72'd1, "wait_idle");
  endtask

  task automatic do_op(input logic [35:0] ta, input logic [35:0] tb2, input logic tas,
                       input logic tbs, input logic [71:0] want, input int gap, input bit track);
    exp_t e;
    wait_idle();
    a = ta; b = tb2; asign = tas; bsign = tbs; in_valid = 1'b1;
    e.want = want;
    e.rise = edge_cnt + 1 + LAT + gap;
    if (track) sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (gap > 0) begin
      @(posedge clk); #1;
      ce = 1'b0;
      repeat (gap) @(posedge clk);
      #1 ce = 1'b1;
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (sbq.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check(72'(sbq.size()), 72'd0, "drain");
    sbq.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{36'hFFFFFFFFF, 36'hFFFFFFFFF, 1'b0, 1'b0, 72'hFF_FFFF_FFE0_0000_0001};
    vecs[1]  = '{36'hFFFFFFFFF, 36'hFFFFFFFFF, 1'b1, 1'b1, 72'h00_0000_0000_0000_0001};
    vecs[2]  = '{36'h800000000, 36'h800000000, 1'b1, 1'b1, 72'h40_0000_0000_0000_0000};
    vecs[3]  = '{36'hFFFFFFFFE, 36'h000000003, 1'b1, 1'b0, 72'hFF_FFFF_FFFF_FFFF_FFFA};
    vecs[4]  = '{36'h000000005, 36'h000000007, 1'b0, 1'b0, 72'h00_0000_0000_0000_0023};
    vecs[5]  = '{36'h800000000, 36'h000000001, 1'b1, 1'b0, 72'hFF_FFFF_FFF8_0000_0000};
    vecs[6]  = '{36'h123456789, 36'h000000010, 1'b0, 1'b0, 72'h00_0000_0012_3456_7890};
    vecs[7]  = '{36'h000000003, 36'hFFFFFFFFF, 1'b0, 1'b1, 72'hFF_FFFF_FFFF_FFFF_FFFD};
    vecs[8]  = '{36'hFFFFFFFFF, 36'hFFFFFFFFF, 1'b0, 1'b1, 72'hFF_FFFF_FFF0_0000_0001};
    vecs[9]  = '{36'h000040000, 36'h000040000, 1'b0, 1'b0, 72'h00_0000_0010_0000_0000};
    vecs[10] = '{36'h800000000, 36'h000000002, 1'b0, 1'b0, 72'h00_0000_0010_0000_0000};
    vecs[11] = '{36'h000000000, 36'hFFFFFFFFF, 1'b1, 1'b1, 72'h00_0000_0000_0000_0000};

    reset = 1'b1; ce = 1'b1; a = '0; b = '0; asign = 1'b0; bsign = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    #12;
    check(dout, 72'd0, "reset_dout");
    check(72'(out_valid), 72'd0, "reset_out_valid");
    check(72'(in_ready), 72'd1, "reset_in_ready");
    @(posedge clk); #1 reset = 1'b0;

    foreach (vecs[k]) begin
      do_op(vecs[k].va, vecs[k].vb, vecs[k].sa, vecs[k].sb, vecs[k].p, 0, 1'b1);
      wait_done();
    end

    // ce held low three cycles in the middle of MUL
    do_op(36'hFFFFFFFFF, 36'hFFFFFFFFF, 1'b0, 1'b0, 72'hFF_FFFF_FFE0_0000_0001, 3, 1'b1);
    wait_done();

    // Backpressure for 10 DONE cycles, with in_valid pulsed while busy
    out_ready = 1'b0;
    do_op(36'hFFFFFFFFE, 36'h000000003, 1'b1, 1'b0, 72'hFF_FFFF_FFFF_FFFF_FFFA, 0, 1'b1);
    repeat (LAT + 2) @(posedge clk);
    #1 a = 36'd1; b = 36'd1; asign = 1'b0; bsign = 1'b0; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 check(72'(out_valid), 72'd1, "held_out_valid");
    out_ready = 1'b1;
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    check(dout, 72'hFF_FFFF_FFFF_FFFF_FFFA, "dout_retained");
    check(72'(out_valid), 72'd0, "out_valid_cleared");

    // Asynchronous reset between edges while in MUL
    do_op(36'd5, 36'd7, 1'b0, 1'b0, 72'h23, 0, 1'b0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check(dout, 72'd0, "async_reset_dout");
    check(72'(out_valid), 72'd0, "async_reset_out_valid");
    check(72'(in_ready), 72'd1, "async_reset_in_ready");
    @(posedge clk); #1 reset = 1'b0;
    do_op(36'h123456789, 36'h000000010, 1'b0, 1'b0, 72'h00_0000_0012_3456_7890, 0, 1'b1);
    wait_done();
    repeat (8) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
